// File: rtl/tick_gen_if.sv
// Handshake bundle for the tick generator:
// control inputs in, strobes and countdown out.
interface tick_gen_if #(
  parameter int W = 16
);
  logic         start;
  logic         stop;
  logic         oneshot;
  logic [W-1:0] period;
  logic         tick;
  logic         busy;
  logic         done;
  logic [W-1:0] remain;

  modport master (
    output start, stop, oneshot, period,
    input  tick, busy, done, remain
  );

  modport slave (
    input  start, stop, oneshot, period,
    output tick, busy, done, remain
  );
endinterface

// File: rtl/tick_gen.sv
// Programmable tick generator: periodic or one-shot
// strobe every max(period,1) cycles, with abort.
module tick_gen #(
  parameter int W = 16
) (
  input logic       clk,
  input logic       rst_n,
  tick_gen_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] cnt;
  logic [W-1:0] peff;
  logic         os_q;
  logic         tick_q;
  logic         done_q;
  logic [W-1:0] peff_in;

  assign peff_in = (bus.period == '0) ? W'(1) : bus.period;

  // cnt is held at 0 whenever idle, so remain is just cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      peff   <= W'(1);
      os_q   <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.stop) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (bus.start) begin
        state <= RUN;
        peff  <= peff_in;
        os_q  <= bus.oneshot;
        cnt   <= peff_in - W'(1);
      end else if (state == RUN) begin
        if (cnt == '0) begin
          tick_q <= 1'b1;
          if (os_q) begin
            done_q <= 1'b1;
            state  <= IDLE;
            cnt    <= '0;
          end else begin
            cnt <= peff - W'(1);
          end
        end else begin
          cnt <= cnt - W'(1);
        end
      end
    end
  end

  assign bus.tick   = tick_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state == RUN);
  assign bus.remain = cnt;
endmodule

// File: tb/tb_tick_gen.sv
// Scenario bench for tick_gen: expected output
// vectors queued per cycle, checked after each edge.
module tb_tick_gen;
  localparam int W = 8;

  typedef struct packed {
    logic         tick;
    logic         busy;
    logic         done;
    logic [W-1:0] remain;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t e;
  exp_t got;

  tick_gen_if #(.W(W)) bus ();

  tick_gen #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign got = {bus.tick, bus.busy, bus.done, bus.remain};

  function automatic exp_t mk(logic t, logic b,
                              logic d, int r);
    exp_t x;
    x.tick   = t;
    x.busy   = b;
    x.done   = d;
    x.remain = W'(r);
    return x;
  endfunction

  task automatic cyc(logic s, logic p, logic o,
                     logic [W-1:0] per);
    bus.start   = s;
    bus.stop    = p;
    bus.oneshot = o;
    bus.period  = per;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.start   = 1'b1;
    bus.stop    = 1'b0;
    bus.oneshot = 1'b0;
    bus.period  = 8'd4;
    #3;
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", got, e);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(0, 0, 0, 0));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_hold[%0d] got=%h want=%h", i, got, e);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // start is already present at the first edge after release
  task automatic test_periodic;
    exp_q.push_back(mk(0, 1, 0, 3));
    cyc(1, 0, 0, 8'd4);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL periodic_accept got=%h want=%h", got, e);
    end
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(mk(k % 4 == 0, 1, 0, 3 - k % 4));
      cyc(0, 0, k > 5, 8'd7);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL periodic[%0d] got=%h want=%h", k, got, e);
      end
    end
    exp_q.push_back(mk(0, 0, 0, 0));
    cyc(0, 1, 0, 8'd4);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL periodic_stop got=%h want=%h", got, e);
    end
  endtask

  task automatic test_oneshot;
    exp_q.push_back(mk(0, 1, 0, 2));
    exp_q.push_back(mk(0, 1, 0, 1));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 0));
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(0, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      cyc(k == 0, 0, k > 0 ? 1'b0 : 1'b1, 8'd3);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL oneshot[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  task automatic test_boundary;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(mk(0, 1, 0, 0));
      for (int k = 0; k < 5; k++)
        exp_q.push_back(mk(1, 1, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0));
      for (int k = 0; k < 7; k++) begin
        cyc(k == 0, k == 6, 0, W'(p));
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL period%0d[%0d] got=%h want=%h",
                   p, k, got, e);
        end
      end
    end
    for (int k = 0; k <= 256; k++) begin
      if (k == 0)
        exp_q.push_back(mk(0, 1, 0, 254));
      else if (k < 255)
        exp_q.push_back(mk(0, 1, 0, 254 - k));
      else if (k == 255)
        exp_q.push_back(mk(1, 1, 0, 254));
      else
        exp_q.push_back(mk(0, 0, 0, 0));
      cyc(k == 0, k == 256, 0, 8'hff);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL period_max[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  task automatic test_stop;
    logic [3:0] s, p;
    s = 4'b0001;
    p = 4'b1000;
    exp_q.push_back(mk(0, 1, 0, 2));
    exp_q.push_back(mk(0, 1, 0, 1));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      cyc(s[k], p[k], 0, 8'd3);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stop_due[%0d] got=%h want=%h", k, got, e);
      end
    end
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0));
    s = 4'b1101;
    p = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      cyc(s[k], p[k], 0, 8'd2);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stop_start[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  task automatic test_restart;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(0, 1, 0, 4 - k));
    exp_q.push_back(mk(0, 1, 0, 1));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 1));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      cyc(k == 0 || k == 4, k == 9, 0,
          k < 4 ? 8'd5 : 8'd2);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL restart[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  task automatic test_reset_midrun;
    int ctr;
    int carries;
    ctr = 0;
    carries = 0;
    exp_q.push_back(mk(0, 1, 0, 0));
    cyc(1, 0, 0, 8'd1);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL cnt_accept got=%h want=%h", got, e);
    end
    for (int k = 0; k < 40; k++) begin
      exp_q.push_back(mk(1, 1, 0, 0));
      cyc(0, 0, 0, 8'd1);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cnt_run[%0d] got=%h want=%h", k, got, e);
      end
      if (bus.tick) begin
        if (ctr == 31) carries++;
        ctr = (ctr + 1) % 32;
      end
    end
    checks++;
    if (ctr !== 8 || carries !== 1) begin
      errors++;
      $display("FAIL counter32 got ctr=%0d carries=%0d want 8/1",
               ctr, carries);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_midrun got=%h want=%h", got, e);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(0, 0, 0, 0));
      cyc(0, 0, 0, 8'd4);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL post_reset[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_oneshot;
    test_boundary;
    test_stop;
    test_restart;
    test_reset_midrun;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
